// File: rtl/route_matrix.sv
// Serially configured V x H crossbar with a shadow/active frame pair; build option ROUTE_OUT_REG_EN.
// Latency: V_o/H_o combinational from V_i/H_i, or 1 clk when ROUTE_OUT_REG_EN is defined.
// Backpressure: none; cfg_commit outside ARMED is dropped and sets the sticky cfg_err.
module route_matrix #(
    parameter int V = 4,
    parameter int H = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cfg_en,
    input  logic         cfg_din,
    input  logic         cfg_commit,
    output logic         cfg_dout,
    output logic         cfg_valid,
    output logic         cfg_err,
    input  logic [V-1:0] V_i,
    output logic [V-1:0] V_o,
    input  logic [H-1:0] H_i,
    output logic [H-1:0] H_o
);
    localparam int N  = V * H;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, ARMED} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          do_shift, do_commit, do_err;
    logic [N-1:0]  shadow, active, shadow_sh;
    logic [V-1:0]  v_nxt;
    logic [H-1:0]  h_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE, ARMED: begin
                if (state == ARMED && cfg_commit) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cfg_en) begin
                    // A single-bit frame is complete after its first shift
                    if (N == 1) begin
                        state_nxt = ARMED;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = LOAD;
                        cnt_nxt   = CW'(1);
                    end
                end
            end
            LOAD: begin
                if (cfg_en) begin
                    if (cnt == CW'(N - 1)) begin
                        state_nxt = ARMED;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        do_commit = (state == ARMED) && cfg_commit;
        do_shift  = cfg_en && !do_commit;
        do_err    = cfg_commit && (state != ARMED);
    end

    generate
        if (N == 1) begin : g_sh_one
            assign shadow_sh = cfg_din;
        end else begin : g_sh_many
            assign shadow_sh = {cfg_din, shadow[N-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow    <= '0;
            active    <= '0;
            cfg_valid <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            if (do_shift) shadow <= shadow_sh;
            if (do_commit) begin
                active    <= shadow;
                cfg_valid <= 1'b1;
                cfg_err   <= 1'b0;
            end else if (do_err) begin
                cfg_err <= 1'b1;
            end
        end
    end

    assign cfg_dout = shadow[0];

    // Sweep rows top to bottom; v_nxt carries each column's N track down, w the row's W track east.
    always_comb begin
        logic w, p, o;
        w     = 1'b0;
        p     = 1'b0;
        o     = 1'b0;
        v_nxt = V_i;
        h_nxt = '0;
        for (int x = 0; x < H; x++) begin
            w = H_i[x];
            for (int y = 0; y < V; y++) begin
                p = active[x*V+y];
                o = v_nxt[y] | w;
                v_nxt[y] = p ? o : v_nxt[y];
                w        = p ? o : w;
            end
            h_nxt[x] = w;
        end
    end

`ifdef ROUTE_OUT_REG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            V_o <= '0;
            H_o <= '0;
        end else begin
            V_o <= v_nxt;
            H_o <= h_nxt;
        end
    end
`else
    assign V_o = v_nxt;
    assign H_o = h_nxt;
`endif

endmodule

// File: tb/tb_route_matrix.sv
// Scoreboard bench for route_matrix at V=H=4: expected routes/serial bits queued at drive, compared at sample.
module tb_route_matrix;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cfg_en = 1'b0, cfg_din = 1'b0, cfg_commit = 1'b0;
    logic       cfg_dout, cfg_valid, cfg_err;
    logic [3:0] V_i = '0, H_i = '0;
    logic [3:0] V_o, H_o;

    int total = 0;
    int bad   = 0;

    logic [15:0] shadow_m = '0;
    logic [7:0]  route_q[$];
    logic        dout_q[$];

    route_matrix #(.V(4), .H(4)) dut (
        .clk(clk), .rst(rst),
        .cfg_en(cfg_en), .cfg_din(cfg_din), .cfg_commit(cfg_commit),
        .cfg_dout(cfg_dout), .cfg_valid(cfg_valid), .cfg_err(cfg_err),
        .V_i(V_i), .V_o(V_o), .H_i(H_i), .H_o(H_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // All tasks start and end 1 time unit after a rising edge.
    task automatic shift_bit(input logic b);
        cfg_en  = 1'b1;
        cfg_din = b;
        @(posedge clk);
        #1;
        cfg_en   = 1'b0;
        shadow_m = {b, shadow_m[15:1]};
        dout_q.push_back(shadow_m[0]);
        chk("dout", {31'd0, cfg_dout}, {31'd0, dout_q.pop_front()});
    endtask

    task automatic shift_frame(input logic [15:0] f);
        for (int k = 0; k < 16; k++) shift_bit(f[k]);
    endtask

    task automatic commit();
        cfg_commit = 1'b1;
        @(posedge clk);
        #1;
        cfg_commit = 1'b0;
    endtask

    task automatic route(input string tag, input logic [3:0] vi, input logic [3:0] hi,
                         input logic [3:0] ev, input logic [3:0] eh);
        logic [7:0] exp;
        route_q.push_back({ev, eh});
        V_i = vi;
        H_i = hi;
`ifdef ROUTE_OUT_REG_EN
        @(posedge clk);
        #1;
`endif
        #3;
        exp = route_q.pop_front();
        chk(tag, {24'd0, V_o, H_o}, {24'd0, exp});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        chk("rst_valid", {31'd0, cfg_valid}, 32'd0);
        chk("rst_err",   {31'd0, cfg_err},   32'd0);
        chk("rst_dout",  {31'd0, cfg_dout},  32'd0);
`ifdef ROUTE_OUT_REG_EN
        chk("rst_out", {24'd0, V_o, H_o}, 32'd0);
`endif
        @(posedge clk);
        #1;
        rst      = 1'b0;
        shadow_m = '0;
    endtask

    initial begin
        #1;
        do_reset();

        // Pass-through after reset
        route("pass0", 4'b1010, 4'b0101, 4'b1010, 4'b0101);
        route("pass1", 4'b0110, 4'b1001, 4'b0110, 4'b1001);
        chk("pass_valid", {31'd0, cfg_valid}, 32'd0);

        // Every node programmed
        shift_frame(16'hFFFF);
        commit();
        chk("ones_valid", {31'd0, cfg_valid}, 32'd1);
        chk("ones_err",   {31'd0, cfg_err},   32'd0);
        route("ones_a", 4'b0001, 4'b0000, 4'b1111, 4'b1111);
        route("ones_b", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        route("ones_c", 4'b0000, 4'b0100, 4'b1111, 4'b1100);

        // Single node (row 1, column 1)
        shift_frame(16'h0020);
        commit();
        route("n5_a", 4'b0010, 4'b0000, 4'b0010, 4'b0010);
        route("n5_b", 4'b0000, 4'b0010, 4'b0010, 4'b0010);
        route("n5_c", 4'b0001, 4'b0000, 4'b0001, 4'b0000);

        // Early commit is rejected, frame can still be completed
        do_reset();
        for (int k = 0; k < 10; k++) shift_bit(1'b1);
        commit();
        chk("early_err",   {31'd0, cfg_err},   32'd1);
        chk("early_valid", {31'd0, cfg_valid}, 32'd0);
        route("early_pass", 4'b1010, 4'b0101, 4'b1010, 4'b0101);
        shift_bit(1'b1);
        chk("err_sticky", {31'd0, cfg_err}, 32'd1);
        for (int k = 0; k < 5; k++) shift_bit(1'b1);
        commit();
        chk("late_err",   {31'd0, cfg_err},   32'd0);
        chk("late_valid", {31'd0, cfg_valid}, 32'd1);
        route("late_route", 4'b0001, 4'b0000, 4'b1111, 4'b1111);
        commit();
        chk("idle_err",   {31'd0, cfg_err},   32'd1);
        chk("idle_valid", {31'd0, cfg_valid}, 32'd1);
        route("idle_route", 4'b0001, 4'b0000, 4'b1111, 4'b1111);

        // Commit beats a simultaneous shift in ARMED
        do_reset();
        shift_frame(16'h0001);
        cfg_en     = 1'b1;
        cfg_din    = 1'b0;
        cfg_commit = 1'b1;
        @(posedge clk);
        #1;
        cfg_en     = 1'b0;
        cfg_commit = 1'b0;
        chk("win_valid", {31'd0, cfg_valid}, 32'd1);
        chk("win_dout",  {31'd0, cfg_dout},  {31'd0, shadow_m[0]});
        route("win_route", 4'b0000, 4'b0001, 4'b0001, 4'b0001);
        commit();
        chk("win_idle_err", {31'd0, cfg_err}, 32'd1);

        // Reset in the middle of a frame discards it
        do_reset();
        for (int k = 0; k < 7; k++) shift_bit(1'b1);
        do_reset();
        route("mid_pass", 4'b1010, 4'b0101, 4'b1010, 4'b0101);
        shift_frame(16'h0020);
        commit();
        chk("mid_valid", {31'd0, cfg_valid}, 32'd1);
        chk("mid_err",   {31'd0, cfg_err},   32'd0);
        route("mid_route", 4'b0010, 4'b0000, 4'b0010, 4'b0010);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/route_matrix.md
ROUTE_MATRIX -- requirements
Module: route_matrix

Interface
REQ-001 SHALL have parameter V, default 4: vertical track count (columns); legal range 1..32.
REQ-002 SHALL have parameter H, default 4: horizontal track count (rows); legal range 1..32.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port cfg_en, input, 1: shift one configuration bit this cycle.
REQ-006 SHALL have port cfg_din, input, 1: serial configuration data.
REQ-007 SHALL have port cfg_commit, input, 1: request transfer of shadow frame to active frame.
REQ-008 SHALL have port cfg_dout, output, 1: serial chain out, equal to shadow[0], for daisy-chaining.
REQ-009 SHALL have port cfg_valid, output, 1: active frame has been loaded by a commit.
REQ-010 SHALL have port cfg_err, output, 1: sticky flag for an illegal commit.
REQ-011 SHALL have ports V_i and V_o, input and output respectively, V bits each: vertical tracks in and out.
REQ-012 SHALL have ports H_i and H_o, input and output respectively, H bits each: horizontal tracks in and out.

Function
REQ-013 SHALL hold a V*H-bit shadow register and a V*H-bit active register; node (row x, column y) uses active[x*V+y].
REQ-014 On a cycle with cfg_en=1 and no accepted commit, SHALL set shadow <= {cfg_din, shadow[V*H-1:1]}, so the k-th bit of a frame (k counted from 0) lands at index k.
REQ-015 Node function: E = prog ? (N|W) : W; S = prog ? (N|W) : N.
REQ-016 Tracks chain row-major: row x takes W from H_i[x] and drives H_o[x] from column V-1; column y takes N from V_i[y] and drives V_o[y] from row H-1.
REQ-017 Configuration FSM states SHALL be IDLE, LOAD and ARMED, with a bit counter of width clog2(V*H) that counts 0..V*H-1.
REQ-018 IDLE: cfg_en=1 shifts, sets count=1 and moves to LOAD; when V*H=1, moves directly to ARMED with count=0.
REQ-019 LOAD: each cfg_en increments count; the shift that completes a frame (count=V*H-1) wraps count to 0 and moves to ARMED.
REQ-020 ARMED: cfg_commit=1 copies shadow to active the next edge, sets cfg_valid=1, clears cfg_err, and returns to IDLE.
REQ-021 ARMED: cfg_en=1 without cfg_commit shifts, sets count=1 and moves to LOAD, starting a new frame.
REQ-022 ARMED: cfg_en=1 together with cfg_commit=1 SHALL let the commit win and suppress the shift.
REQ-023 cfg_commit in IDLE or LOAD SHALL be ignored (active register, state and count unchanged) and SHALL set cfg_err=1.
REQ-024 The active register SHALL change only on an accepted commit, so the datapath never sees a partial frame.

Reset
REQ-025 rst=1 SHALL immediately clear shadow, active, count, cfg_valid, cfg_err and cfg_dout, and force the FSM to IDLE.
REQ-026 After reset, with all prog bits 0, the matrix SHALL pass through: V_o=V_i and H_o=H_i.
REQ-027 Reset asserted mid-load SHALL discard the partial frame; the next frame starts at bit 0.

Configuration
REQ-028 Macro ROUTE_OUT_REG_EN: when defined, V_o and H_o SHALL be registered (1-cycle latency, reset value 0).
REQ-029 Without ROUTE_OUT_REG_EN, V_o and H_o SHALL be purely combinational from V_i, H_i and active (0-cycle latency).

Verification (V=H=4, macro undefined unless stated)
REQ-030 After reset, V_i=4'b1010 and H_i=4'b0101 -> V_o=4'b1010 and H_o=4'b0101 in the same cycle; cfg_valid=0.
REQ-031 Shift 16 ones, then commit -> cfg_valid=1 after the edge; then V_i=4'b0001, H_i=4'b0000 -> V_o=4'b1111 and H_o=4'b1111.
REQ-032 Shift a frame with only bit 5 set, then commit; V_i=4'b0010, H_i=4'b0000 -> V_o=4'b0010 and H_o=4'b0010; cfg_dout tracks shadow[0] during the shift.
REQ-033 Shift 10 bits, then commit -> cfg_err=1, active unchanged (pass-through persists), FSM remains in LOAD; 6 more shifts plus a commit -> cfg_err=0 and cfg_valid=1.
REQ-034 Assert rst after 7 shifts -> all flags 0 and pass-through; a following full 16-bit frame and commit loads correctly.
REQ-035 ROUTE_OUT_REG_EN defined: a change on V_i is seen on V_o exactly one clk later; V_o=0 and H_o=0 during reset.
